dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port,
// asynchronous-read data memory of DEPTH 32-bit words. Requester 0 (CPU) and
// requester 1 (debug/DMA) each hold req until they see their ack. One access
// is performed per cycle. Out-of-range addresses are answered with err and
// never reach the memory write enable.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 100
) (
  input  logic        CLK,
  input  logic        RST,
  // requester 0 (CPU)
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  // requester 1 (debug/DMA)
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  // data memory side
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  // Word count as a 32-bit constant so the range check is a plain unsigned
  // compare across all address bits (0xFFFF_FFFF is out of range).
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   last_r;   // port most recently served; 1 after reset so port 0 wins the first tie
  logic   last_s;

  // Unsigned in-range test for a word address.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr < DEPTH_W);
  endfunction

  // State and last-served pointer registers; reset forces IDLE at once so
  // every decoded output (ack, err, mem_WE) drops without waiting for CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Next-state logic: round-robin on ties, and a port is never re-granted
  // straight from its own SERVE state (it must drop req after its ack).
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          if (last_r) begin
            state_s = SERVE0;
            last_s  = 1'b0;
          end else begin
            state_s = SERVE1;
            last_s  = 1'b1;
          end
        end else if (req0) begin
          state_s = SERVE0;
          last_s  = 1'b0;
        end else if (req1) begin
          state_s = SERVE1;
          last_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE0: begin
        if (req1) begin
          state_s = SERVE1;
          last_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE1: begin
        if (req0) begin
          state_s = SERVE0;
          last_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode: route the served port to the memory, gate the write
  // enable with the range check, and return read data only on reads.
  always_comb begin
    mem_A  = 32'h0000_0000;
    mem_WD = 32'h0000_0000;
    mem_WE = 1'b0;
    ack0   = 1'b0;
    err0   = 1'b0;
    rdata0 = 32'h0000_0000;
    ack1   = 1'b0;
    err1   = 1'b0;
    rdata1 = 32'h0000_0000;
    case (state_r)
      SERVE0: begin
        mem_A  = addr0;
        mem_WD = wdata0;
        ack0   = 1'b1;
        if (addr_ok(addr0)) begin
          mem_WE = we0;
          err0   = 1'b0;
          if (!we0) begin
            rdata0 = mem_RD;
          end else begin
            rdata0 = 32'h0000_0000;
          end
        end else begin
          mem_WE = 1'b0;
          err0   = 1'b1;
          rdata0 = 32'h0000_0000;
        end
      end
      SERVE1: begin
        mem_A  = addr1;
        mem_WD = wdata1;
        ack1   = 1'b1;
        if (addr_ok(addr1)) begin
          mem_WE = we1;
          err1   = 1'b0;
          if (!we1) begin
            rdata1 = mem_RD;
          end else begin
            rdata1 = 32'h0000_0000;
          end
        end else begin
          mem_WE = 1'b0;
          err1   = 1'b1;
          rdata1 = 32'h0000_0000;
        end
      end
      IDLE: begin
        mem_WE = 1'b0;
      end
      default: begin
        mem_WE = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 100-word memory model on the memory
// side, a table of single-port transactions, and hand-written sequences for
// tie-breaking, alternation and reset during a write.
module tb_dmem_arbiter;

  logic        CLK;
  logic        RST;
  logic        req0, we0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:99];
  logic [31:0] exp_mem [0:99];
  bit          mem_inited = 1'b0;

  dmem_arbiter #(.DEPTH(100)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: filled once at the first reset, writes on the rising edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      if (!mem_inited) begin
        for (int i = 0; i < 100; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        mem_inited <= 1'b1;
      end
    end else if (mem_WE && (mem_A < 32'd100)) begin
      mem[mem_A[6:0]] <= mem_WD;
    end
  end

  assign mem_RD = (mem_A < 32'd100) ? mem[mem_A[6:0]] : 32'h0000_0000;

  typedef struct {
    logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
    logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
    logic e_ack0; logic e_err0; logic [31:0] e_rd0;
    logic e_ack1; logic e_err1; logic [31:0] e_rd1;
    logic e_we; logic [31:0] e_a; logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ack0"}, {31'h0, ack0}, 32'h0);
    chk({tag, ".ack1"}, {31'h0, ack1}, 32'h0);
    chk({tag, ".err0"}, {31'h0, err0}, 32'h0);
    chk({tag, ".err1"}, {31'h0, err1}, 32'h0);
    chk({tag, ".mem_WE"}, {31'h0, mem_WE}, 32'h0);
    chk({tag, ".mem_A"}, mem_A, 32'h0);
    chk({tag, ".mem_WD"}, mem_WD, 32'h0);
  endtask

  // One transaction from IDLE: apply, check the ack cycle, let the edge that
  // ends it commit, then drop the request.
  task automatic run_vec(input vec_t v, input int id);
    string t;
    t = $sformatf("v%0d", id);
    @(negedge CLK);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(posedge CLK);
    @(negedge CLK);
    chk({t, ".ack0"}, {31'h0, ack0}, {31'h0, v.e_ack0});
    chk({t, ".err0"}, {31'h0, err0}, {31'h0, v.e_err0});
    chk({t, ".rdata0"}, rdata0, v.e_rd0);
    chk({t, ".ack1"}, {31'h0, ack1}, {31'h0, v.e_ack1});
    chk({t, ".err1"}, {31'h0, err1}, {31'h0, v.e_err1});
    chk({t, ".rdata1"}, rdata1, v.e_rd1);
    chk({t, ".mem_WE"}, {31'h0, mem_WE}, {31'h0, v.e_we});
    chk({t, ".mem_A"}, mem_A, v.e_a);
    chk({t, ".mem_WD"}, mem_WD, v.e_wd);
    if (v.e_we) exp_mem[v.e_a[6:0]] = v.e_wd;
    @(posedge CLK);
    #1;
    clear_inputs();
    check_idle({t, ".idle"});
  endtask

  initial begin
    int n0;
    int n1;
    vec_t v;

    for (int i = 0; i < 100; i++) exp_mem[i] = 32'h1000_0000 + 32'(i);

    //               r0    w0    a0             d0             r1    w1    a1             d1             ack0  err0  rd0            ack1  err1  rd1            we    a              wd
    vecs[0]  = '{1'b1, 1'b1, 32'd13,        32'h0000_00AA, 1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'd13,        32'h0000_00AA};
    vecs[1]  = '{1'b1, 1'b0, 32'd13,        32'h0,         1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'h0000_00AA, 1'b0, 1'b0, 32'h0,         1'b0, 32'd13,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b1, 32'd100,       32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'd100,       32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'hFFFF_FFFF, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'd99,        32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h1000_0063, 1'b0, 32'd99,        32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h8000_0064, 32'h1111_1111, 1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0064, 32'h1111_1111};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b1, 32'd0,         32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'd0,         32'h1234_5678};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,         32'h0,         1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 32'd0,         32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'd99,        32'h5555_AAAA, 1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'd99,        32'h5555_AAAA};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'd99,        32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h5555_AAAA, 1'b0, 32'd99,        32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'd98,        32'hFFFF_0000, 1'b0, 1'b0, 32'd0,         32'h0,         1'b1, 1'b0, 32'h1000_0062, 1'b0, 1'b0, 32'h0,         1'b0, 32'd98,        32'hFFFF_0000};

    // Reset: outputs idle while RST is held.
    RST = 1'b0;
    clear_inputs();
    #1 RST = 1'b1;
    #2;
    check_idle("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_idle("after_reset");

    // Tie right after reset: port 0 first, then port 1, never together.
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd6;
    @(posedge CLK);
    @(negedge CLK);
    chk("tie.c1.ack0", {31'h0, ack0}, 32'h1);
    chk("tie.c1.ack1", {31'h0, ack1}, 32'h0);
    chk("tie.c1.rdata0", rdata0, 32'h1000_0005);
    @(posedge CLK);
    #1 req0 = 1'b0;
    @(negedge CLK);
    chk("tie.c2.ack0", {31'h0, ack0}, 32'h0);
    chk("tie.c2.ack1", {31'h0, ack1}, 32'h1);
    chk("tie.c2.rdata1", rdata1, 32'h1000_0006);
    chk("tie.c2.rdata0", rdata0, 32'h0);
    @(posedge CLK);
    #1 clear_inputs();
    check_idle("tie.idle");

    // Continuous requests from both ports: grants alternate starting with 0.
    n0 = 0;
    n1 = 0;
    @(negedge CLK);
    req0 = 1'b1; addr0 = 32'd3;
    req1 = 1'b1; addr1 = 32'd4;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("alt%0d.ack0", k), {31'h0, ack0}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("alt%0d.ack1", k), {31'h0, ack1}, (k % 2 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("alt%0d.rdata0", k), rdata0, (k % 2 == 0) ? 32'h1000_0003 : 32'h0);
      if (ack0) n0++;
      if (ack1) n1++;
    end
    clear_inputs();
    @(posedge CLK);
    #1;
    chk("alt.count0", 32'(n0), 32'd4);
    chk("alt.count1", 32'(n1), 32'd4);
    check_idle("alt.idle");

    // Single-port transactions from the table.
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset pulsed mid-cycle during a write to word 14.
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd14; wdata0 = 32'hCAFE_F00D;
    @(posedge CLK);
    @(negedge CLK);
    chk("rstw.ack0_before", {31'h0, ack0}, 32'h1);
    chk("rstw.we_before", {31'h0, mem_WE}, 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("rstw.ack0_now", {31'h0, ack0}, 32'h0);
    chk("rstw.we_now", {31'h0, mem_WE}, 32'h0);
    chk("rstw.err0_now", {31'h0, err0}, 32'h0);
    @(posedge CLK);
    #1 clear_inputs();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_idle("rstw.idle");
    chk("rstw.word14", mem[14], 32'h1000_000E);

    // After release arbitration restarts from IDLE: one-cycle ack, old data.
    v = '{1'b1, 1'b0, 32'd14, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0,
          1'b1, 1'b0, 32'h1000_000E, 1'b0, 1'b0, 32'h0, 1'b0, 32'd14, 32'h0};
    run_vec(v, 99);

    // Whole memory against the expected image (out-of-range writes dropped).
    for (int i = 0; i < 100; i++) chk($sformatf("mem[%0d]", i), mem[i], exp_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
